// File: rtl/reg_scoreboard_if.sv
// ID/WB/control bundle for the register hazard scoreboard.
// The scoreboard uses the slave side; the issuing/driving logic uses the master side.
interface reg_scoreboard_if #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned TOT_W    = 7
);
   localparam int unsigned IdxW = $clog2(NUM_REGS);

   logic                flush;
   logic                id_valid;
   logic [IdxW-1:0]     id_rj;
   logic                id_rj_used;
   logic [IdxW-1:0]     id_rk;
   logic                id_rk_used;
   logic                id_wreg_en;
   logic [IdxW-1:0]     id_wreg_index;
   logic                issue_fire;
   logic                wb_valid;
   logic                wb_wreg_en;
   logic [IdxW-1:0]     wb_wreg_index;
   logic                drain_req;
   logic                stall;
   logic                drain_done;
   logic [NUM_REGS-1:0] busy_vec;
   logic [TOT_W-1:0]    inflight;
   logic                underflow_err;

   modport master (
      output flush, id_valid, id_rj, id_rj_used, id_rk, id_rk_used, id_wreg_en, id_wreg_index,
             issue_fire, wb_valid, wb_wreg_en, wb_wreg_index, drain_req,
      input  stall, drain_done, busy_vec, inflight, underflow_err
   );

   modport slave (
      input  flush, id_valid, id_rj, id_rj_used, id_rk, id_rk_used, id_wreg_en, id_wreg_index,
             issue_fire, wb_valid, wb_wreg_en, wb_wreg_index, drain_req,
      output stall, drain_done, busy_vec, inflight, underflow_err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard between ID and EXE: per-GPR in-flight writer counters,
// RAW/saturation stall generation and a drain sequencer for serialising instructions.
module reg_scoreboard #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned CNT_W    = 2,
   parameter int unsigned TOT_W    = 7
) (
   input logic             clk,
   input logic             reset,
   reg_scoreboard_if.slave sb
);
   localparam int unsigned      IdxW   = $clog2(NUM_REGS);
   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

   state_e              r_state;
   logic                r_drain_done;
   logic                r_underflow;
   logic [CNT_W-1:0]    r_cnt [NUM_REGS];
   logic [TOT_W-1:0]    r_inflight;

   logic                w_rj_haz;
   logic                w_rk_haz;
   logic                w_rd_sat;
   logic                w_stall;
   logic                w_inc;
   logic                w_dec_req;
   logic                w_same;
   logic                w_underflow;
   logic                w_dec;
   logic                w_inc_net;
   logic [NUM_REGS-1:0] w_busy;

   // Hazards look at registered counters only; a writeback frees its consumer one cycle later.
   always_comb begin
      w_rj_haz = sb.id_rj_used && (sb.id_rj != '0) && (r_cnt[sb.id_rj] != '0);
      w_rk_haz = sb.id_rk_used && (sb.id_rk != '0) && (r_cnt[sb.id_rk] != '0);
      w_rd_sat = sb.id_wreg_en && (sb.id_wreg_index != '0) && (r_cnt[sb.id_wreg_index] == CntMax);
      w_stall  = reset || (sb.id_valid && (w_rj_haz || w_rk_haz || w_rd_sat))
                 || (r_state != StIdle);
   end

   // Issue under stall is ignored; an issue+wb pair on the same register cancels out.
   always_comb begin
      w_inc       = sb.issue_fire && !w_stall && sb.id_wreg_en && (sb.id_wreg_index != '0)
                    && (r_cnt[sb.id_wreg_index] != CntMax);
      w_dec_req   = sb.wb_valid && sb.wb_wreg_en && (sb.wb_wreg_index != '0);
      w_same      = w_inc && w_dec_req && (sb.id_wreg_index == sb.wb_wreg_index);
      w_underflow = w_dec_req && !w_same && (r_cnt[sb.wb_wreg_index] == '0);
      w_dec       = w_dec_req && !w_same && !w_underflow;
      w_inc_net   = w_inc && !w_same;
   end

   always_ff @(posedge clk) begin
      if (reset || sb.flush) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         if (w_inc_net) begin
            r_cnt[sb.id_wreg_index] <= r_cnt[sb.id_wreg_index] + 1'b1;
         end
         if (w_dec) begin
            r_cnt[sb.wb_wreg_index] <= r_cnt[sb.wb_wreg_index] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || sb.flush) begin
         r_inflight <= '0;
      end else begin
         r_inflight <= r_inflight + {{(TOT_W-1){1'b0}}, w_inc_net}
                                  - {{(TOT_W-1){1'b0}}, w_dec};
      end
   end

   // Sticky across flush; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_underflow <= 1'b0;
      end else if (!sb.flush && w_underflow) begin
         r_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || sb.flush) begin
         r_state      <= StIdle;
         r_drain_done <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_drain_done <= 1'b0;
               if (sb.drain_req) begin
                  r_state <= StDrain;
               end
            end
            StDrain: begin
               if (r_inflight == '0) begin
                  r_state      <= StDone;
                  r_drain_done <= 1'b1;
               end
            end
            StDone: begin
               r_state      <= StIdle;
               r_drain_done <= 1'b0;
            end
            default: begin
               r_state      <= StIdle;
               r_drain_done <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         w_busy[i] = (r_cnt[i] != '0);
      end
      w_busy[0] = 1'b0;
   end

   assign sb.stall         = w_stall;
   assign sb.drain_done    = r_drain_done;
   assign sb.busy_vec      = w_busy;
   assign sb.inflight      = r_inflight;
   assign sb.underflow_err = r_underflow;

endmodule
